// File: rtl/si5340_page_writer_if.sv
// ---------------------------------------------------------------------------
// si5340_page_writer_if
// Request channel from the Si5340 configuration sequencer (master) into the
// register-transaction engine si5340_page_writer (slave).
//   s_valid : request valid
//   s_ready : request accepted on a cycle with s_valid && s_ready
//   s_data  : [23:16] page, [15:8] register offset, [7:0] write data
//   s_rd    : 1 = read request, 0 = write request (sampled with s_data)
// ---------------------------------------------------------------------------
interface si5340_page_writer_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_rd;

  modport master (output s_valid, output s_data, output s_rd, input s_ready);
  modport slave  (input s_valid, input s_data, input s_rd, output s_ready);
endinterface

// File: rtl/si5340_page_writer.sv
// ---------------------------------------------------------------------------
// si5340_page_writer
// Register-transaction engine between the Si5340 configuration sequencer and
// the I2C byte controller. One 24-bit request is taken at a time; the Si5340
// page register is cached so a page-select write is only issued on a page
// change. Each request becomes a series of byte commands; the slave ACK is
// checked after each transmitted byte and a NACK aborts the request.
//
// Ports
//   clk_i, arstn_i      : clock (rising edge), asynchronous active-low reset
//   req_if (slave)      : valid/ready request channel (page, offset, data, rd)
//   flush_i             : invalidate the page cache
//   err_clr_i           : clear the sticky error flag
//   start_o/stop_o/write_o/read_o/ack_in_o/din_o : byte-controller command
//   dout_i, cmd_ack_i, ack_out_i                 : byte-controller response
//   busy_o              : transaction in progress
//   done_o              : 1-cycle pulse at the end of every accepted request
//   rdata_o             : last successful read result
//   rdata_valid_o       : 1-cycle pulse with done_o on a successful read
//   err_o               : sticky NACK flag
// ---------------------------------------------------------------------------
module si5340_page_writer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h74,
  parameter logic [7:0] PAGE_REG   = 8'h01
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  si5340_page_writer_if.slave         req_if,
  input  logic                        flush_i,
  input  logic                        err_clr_i,
  output logic                        start_o,
  output logic                        stop_o,
  output logic                        write_o,
  output logic                        read_o,
  output logic                        ack_in_o,
  output logic [7:0]                  din_o,
  input  logic [7:0]                  dout_i,
  input  logic                        cmd_ack_i,
  input  logic                        ack_out_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [7:0]                  rdata_o,
  output logic                        rdata_valid_o,
  output logic                        err_o
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PG_ADDR    = 4'd1,
    PG_REG     = 4'd2,
    PG_DATA    = 4'd3,
    RG_ADDR    = 4'd4,
    RG_OFF     = 4'd5,
    RG_DATA    = 4'd6,
    RD_RSTART  = 4'd7,
    RD_BYTE    = 4'd8,
    ABORT_STOP = 4'd9
  } state_e;

  localparam logic [7:0] ADDR_WR = {SLAVE_ADDR, 1'b0};
  localparam logic [7:0] ADDR_RD = {SLAVE_ADDR, 1'b1};

  state_e      state_q, state_d;
  logic        cmd_active_q, cmd_active_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        ack_in_q, ack_in_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  off_q, off_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic [7:0]  cache_page_q, cache_page_d;
  logic        cache_valid_q, cache_valid_d;
  logic        flush_seen_q, flush_seen_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        st_start_s, st_stop_s, st_write_s, st_read_s, st_ack_in_s;
  logic [7:0]  st_din_s;
  logic        accept_s;
  logic        nack_s;

  assign accept_s = (state_q == IDLE) && req_if.s_valid && ready_q;

  // Byte command that belongs to the current state.
  always_comb begin
    st_start_s  = 1'b0;
    st_stop_s   = 1'b0;
    st_write_s  = 1'b0;
    st_read_s   = 1'b0;
    st_ack_in_s = 1'b0;
    st_din_s    = 8'h00;
    case (state_q)
      PG_ADDR:    begin st_start_s = 1'b1; st_write_s = 1'b1; st_din_s = ADDR_WR; end
      PG_REG:     begin st_write_s = 1'b1; st_din_s = PAGE_REG; end
      PG_DATA:    begin st_write_s = 1'b1; st_stop_s = 1'b1; st_din_s = page_q; end
      RG_ADDR:    begin st_start_s = 1'b1; st_write_s = 1'b1; st_din_s = ADDR_WR; end
      RG_OFF:     begin st_write_s = 1'b1; st_din_s = off_q; end
      RG_DATA:    begin st_write_s = 1'b1; st_stop_s = 1'b1; st_din_s = wdata_q; end
      RD_RSTART:  begin st_start_s = 1'b1; st_write_s = 1'b1; st_din_s = ADDR_RD; end
      RD_BYTE:    begin st_read_s = 1'b1; st_stop_s = 1'b1; st_ack_in_s = 1'b1; end
      ABORT_STOP: begin st_stop_s = 1'b1; end
      default:    begin st_din_s = 8'h00; end
    endcase
  end

  // Next-state, command register, page cache and status update.
  always_comb begin
    state_d       = state_q;
    cmd_active_d  = cmd_active_q;
    start_d       = start_q;
    stop_d        = stop_q;
    write_d       = write_q;
    read_d        = read_q;
    ack_in_d      = ack_in_q;
    din_d         = din_q;
    page_d        = page_q;
    off_d         = off_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    cache_page_d  = cache_page_q;
    cache_valid_d = cache_valid_q;
    flush_seen_d  = flush_seen_q;
    err_d         = err_q;
    done_d        = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    nack_s        = 1'b0;

    if (accept_s) begin
      page_d       = req_if.s_data[23:16];
      off_d        = req_if.s_data[15:8];
      wdata_d      = req_if.s_data[7:0];
      rd_d         = req_if.s_rd;
      flush_seen_d = 1'b0;
      if (!cache_valid_q || flush_i || (req_if.s_data[23:16] != cache_page_q)) begin
        state_d = PG_ADDR;
      end else begin
        state_d = RG_ADDR;
      end
    end else if (state_q == IDLE) begin
      state_d = IDLE;
    end else if (!cmd_active_q) begin
      // Entry cycle of a byte state: commands stay low for this cycle,
      // which also provides the idle gap between consecutive bytes.
      cmd_active_d = 1'b1;
      start_d      = st_start_s;
      stop_d       = st_stop_s;
      write_d      = st_write_s;
      read_d       = st_read_s;
      ack_in_d     = st_ack_in_s;
      din_d        = st_din_s;
    end else if (cmd_ack_i) begin
      cmd_active_d = 1'b0;
      start_d      = 1'b0;
      stop_d       = 1'b0;
      write_d      = 1'b0;
      read_d       = 1'b0;
      ack_in_d     = 1'b0;
      case (state_q)
        RD_BYTE: begin
          rdata_d       = dout_i;
          rdata_valid_d = 1'b1;
          done_d        = 1'b1;
          state_d       = IDLE;
        end
        ABORT_STOP: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          if (ack_out_i) begin
            nack_s = 1'b1;
            // A byte that already carried stop has closed the bus itself.
            if (st_stop_s) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = ABORT_STOP;
            end
          end else begin
            case (state_q)
              PG_ADDR: state_d = PG_REG;
              PG_REG:  state_d = PG_DATA;
              PG_DATA: begin
                cache_page_d  = page_q;
                // A flush seen during this sequence keeps the cache invalid.
                cache_valid_d = !flush_seen_q;
                state_d       = RG_ADDR;
              end
              RG_ADDR: state_d = RG_OFF;
              RG_OFF: begin
                if (rd_q) begin
                  state_d = RD_RSTART;
                end else begin
                  state_d = RG_DATA;
                end
              end
              RG_DATA: begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
              RD_RSTART: state_d = RD_BYTE;
              default:   state_d = IDLE;
            endcase
          end
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (nack_s || flush_i) begin
      cache_valid_d = 1'b0;
    end else begin
      cache_valid_d = cache_valid_d;
    end

    if (flush_i) begin
      flush_seen_d = (state_q != IDLE);
    end else begin
      flush_seen_d = flush_seen_d;
    end

    // A new NACK wins over a simultaneous clear.
    if (nack_s) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= IDLE;
      cmd_active_q  <= 1'b0;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      ack_in_q      <= 1'b0;
      din_q         <= 8'h00;
      page_q        <= 8'h00;
      off_q         <= 8'h00;
      wdata_q       <= 8'h00;
      rd_q          <= 1'b0;
      cache_page_q  <= 8'h00;
      cache_valid_q <= 1'b0;
      flush_seen_q  <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_active_q  <= cmd_active_d;
      start_q       <= start_d;
      stop_q        <= stop_d;
      write_q       <= write_d;
      read_q        <= read_d;
      ack_in_q      <= ack_in_d;
      din_q         <= din_d;
      page_q        <= page_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      cache_page_q  <= cache_page_d;
      cache_valid_q <= cache_valid_d;
      flush_seen_q  <= flush_seen_d;
      err_q         <= err_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
    end
  end

  assign req_if.s_ready = ready_q;
  assign start_o        = start_q;
  assign stop_o         = stop_q;
  assign write_o        = write_q;
  assign read_o         = read_q;
  assign ack_in_o       = ack_in_q;
  assign din_o          = din_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign rdata_o        = rdata_q;
  assign rdata_valid_o  = rdata_valid_q;
  assign err_o          = err_q;

endmodule
